// File: rtl/pipe_regfile_pkg.sv
// Shared types and helpers for the pipelined register file.
package pipe_regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int unsigned RF_XLEN_DEF  = 32;
  localparam int unsigned RF_NREGS_DEF = 32;
  localparam int unsigned RF_NRD_DEF   = 2;

  // Address width for n registers; never below one bit.
  function automatic int unsigned rf_aw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// Decode/writeback side bus of the register file: read ports, writeback, issue and control.
interface pipe_regfile_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
);
  import pipe_regfile_pkg::*;

  localparam int unsigned AW = rf_aw(NREGS);

  logic                 init_ready;
  logic                 clr_req;
  logic [NRD*AW-1:0]    rd_adr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_pend;
  logic                 w_en;
  logic [AW-1:0]        w_adr;
  logic [XLEN-1:0]      w_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_adr;
  logic                 flush;

  modport master (
    input  init_ready, rd_data, rd_pend,
    output clr_req, rd_adr, w_en, w_adr, w_data, iss_en, iss_adr, flush
  );

  modport slave (
    output init_ready, rd_data, rd_pend,
    input  clr_req, rd_adr, w_en, w_adr, w_data, iss_en, iss_adr, flush
  );

endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// Per-register pending bits: issue sets, flush/writeback clear, with per-port lookup
// that already sees a same-cycle writeback as having retired the producer.
module rf_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              iss_v,
  input  logic [AW-1:0]     iss_adr,
  input  logic              flush,
  input  logic              wr_v,
  input  logic [AW-1:0]     wr_adr,
  input  logic [NRD*AW-1:0] rd_adr,
  output logic [NRD-1:0]    rd_pend_c
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Issue beats flush beats writeback; clear wipes everything.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (iss_v && (iss_adr == AW'(r))) begin
        pend_d[r] = 1'b1;
      end else if (flush) begin
        pend_d[r] = 1'b0;
      end else if (wr_v && (wr_adr == AW'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    if (clear) begin
      pend_d = '0;
    end
    if (ZR) begin
      pend_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    logic [AW-1:0] adr;
    adr       = '0;
    rd_pend_c = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      adr          = rd_adr[k*AW +: AW];
      rd_pend_c[k] = pend_q[adr]
                   & ~(wr_v && (wr_adr == adr))
                   & ~(ZR && (adr == '0));
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-read-port register file with write bypass, pending scoreboard and a
// sequenced zero-clear so the storage array needs no reset.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN_DEF,
  parameter int unsigned NREGS    = RF_NREGS_DEF,
  parameter int unsigned NRD      = RF_NRD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  pipe_regfile_if.slave  bus
);

  localparam int unsigned AW = rf_aw(NREGS);
  localparam bit          ZR = (ZERO_REG != 0);

  rf_state_e       state_q;
  rf_state_e       state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [AW-1:0]   clr_cnt_d;
  logic            init_ready_q;

  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [XLEN-1:0] ram_wd;
  logic [XLEN-1:0] ram [NREGS];

  logic            run;
  logic            live;
  logic            wr_v;
  logic            iss_v;
  logic            sb_clear;
  logic [NRD-1:0]  sb_pend_c;
  logic [NRD*XLEN-1:0] rd_data_c;

  // Sequencing: INIT walks the array writing zeros, RUN serves traffic.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_wa    = bus.w_adr;
    ram_wd    = bus.w_data;
    run       = 1'b0;
    sb_clear  = 1'b0;
    unique case (state_q)
      RF_INIT: begin
        ram_we    = 1'b1;
        ram_wa    = clr_cnt_q;
        ram_wd    = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        run = 1'b1;
        if (bus.clr_req) begin
          state_d  = RF_INIT;
          sb_clear = 1'b1;
        end else begin
          ram_we = wr_v;
        end
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RF_INIT;
      clr_cnt_q    <= '0;
      init_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      init_ready_q <= (state_d == RF_RUN);
    end
  end

  // Traffic is honoured only in RUN and not while a clear is being requested.
  assign live  = run && !bus.clr_req;
  assign wr_v  = live && bus.w_en && !(ZR && (bus.w_adr == '0));
  assign iss_v = live && bus.iss_en && !(ZR && (bus.iss_adr == '0));

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
  end

  always_comb begin
    logic [AW-1:0] adr;
    adr       = '0;
    rd_data_c = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      adr = bus.rd_adr[k*AW +: AW];
      if (!run || (ZR && (adr == '0))) begin
        rd_data_c[k*XLEN +: XLEN] = '0;
      end else if (wr_v && (bus.w_adr == adr)) begin
        rd_data_c[k*XLEN +: XLEN] = bus.w_data;
      end else begin
        rd_data_c[k*XLEN +: XLEN] = ram[adr];
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clear     (sb_clear),
    .iss_v     (iss_v),
    .iss_adr   (bus.iss_adr),
    .flush     (live && bus.flush),
    .wr_v      (wr_v),
    .wr_adr    (bus.w_adr),
    .rd_adr    (bus.rd_adr),
    .rd_pend_c (sb_pend_c)
  );

  assign bus.init_ready = init_ready_q;
  assign bus.rd_data    = rd_data_c;
  assign bus.rd_pend    = run ? sb_pend_c : '0;

endmodule
